// File: rtl/addsub_pipe.sv
// rtl/addsub_pipe.sv - pipelined add/subtract unit with valid/ready handshake; optional counters under ADDSUB_STATS_EN
module addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int SIGNED = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_op,
  input  logic             in_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg
`ifdef ADDSUB_STATS_EN
  ,
  input  logic             stat_clr,
  output logic [31:0]      stat_ops,
  output logic [31:0]      stat_ovf
`endif
);

  localparam int MSB = WIDTH - 1;

  // flag bundle layout: {carry, ovf, zero, neg}
  logic [STAGES-1:0] vld;
  logic [WIDTH-1:0]  res_q [STAGES];
  logic [3:0]        flg_q [STAGES];

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             carry;
  logic             ovf;
  logic [WIDTH-1:0] res;
  logic             zero;
  logic             neg;

  // Global stall: every stage moves together or holds together
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  // Stage-1 arithmetic on WIDTH+1 bits, overflow detect and optional clamp
  always_comb begin
    b_eff = in_op ? ~in_b : in_b;
    sum   = {1'b0, in_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, in_op};
    carry = sum[WIDTH];
    if (SIGNED != 0) begin
      ovf = (in_a[MSB] == b_eff[MSB]) & (sum[MSB] != in_a[MSB]);
    end else begin
      ovf = in_op ? ~carry : carry;
    end
    res = sum[WIDTH-1:0];
    if (in_sat && ovf) begin
      if (SIGNED != 0) begin
        res = in_a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
        res = in_op ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
      end
    end
    zero = (res == '0);
    neg  = res[MSB];
  end

  // Pipeline registers: load stage 1 from the arithmetic, shift the rest on advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < STAGES; i++) begin
        res_q[i] <= '0;
        flg_q[i] <= '0;
      end
    end else if (adv) begin
      vld[0]   <= in_valid;
      res_q[0] <= res;
      flg_q[0] <= {carry, ovf, zero, neg};
      for (int i = 1; i < STAGES; i++) begin
        vld[i]   <= vld[i-1];
        res_q[i] <= res_q[i-1];
        flg_q[i] <= flg_q[i-1];
      end
    end
  end

  assign out_valid  = vld[STAGES-1];
  assign out_result = res_q[STAGES-1];
  assign out_carry  = flg_q[STAGES-1][3];
  assign out_ovf    = flg_q[STAGES-1][2];
  assign out_zero   = flg_q[STAGES-1][1];
  assign out_neg    = flg_q[STAGES-1][0];

`ifdef ADDSUB_STATS_EN
  logic out_xfer;
  assign out_xfer = out_valid & out_ready;

  // Transfer counters; clear has priority over counting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops <= '0;
      stat_ovf <= '0;
    end else if (stat_clr) begin
      stat_ops <= '0;
      stat_ovf <= '0;
    end else if (out_xfer) begin
      stat_ops <= stat_ops + 32'd1;
      if (out_ovf) begin
        stat_ovf <= stat_ovf + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_addsub_pipe.sv
// tb/tb_addsub_pipe.sv - directed self-checking bench for addsub_pipe (signed and unsigned instances)
module tb_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_op = 1'b0;
  logic        in_sat = 1'b0;
  logic        out_ready = 1'b1;

  logic        s_in_ready, s_valid, s_carry, s_ovf, s_zero, s_neg;
  logic [31:0] s_result;
  logic        u_in_ready, u_valid, u_carry, u_ovf, u_zero, u_neg;
  logic [31:0] u_result;

`ifdef ADDSUB_STATS_EN
  logic        stat_clr = 1'b0;
  logic [31:0] s_stat_ops, s_stat_ovf, u_stat_ops, u_stat_ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  addsub_pipe #(.WIDTH(32), .STAGES(2), .SIGNED(1)) u_sgn (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_sat(in_sat),
    .out_valid(s_valid), .out_ready(out_ready),
    .out_result(s_result), .out_carry(s_carry), .out_ovf(s_ovf),
    .out_zero(s_zero), .out_neg(s_neg)
`ifdef ADDSUB_STATS_EN
    , .stat_clr(stat_clr), .stat_ops(s_stat_ops), .stat_ovf(s_stat_ovf)
`endif
  );

  addsub_pipe #(.WIDTH(32), .STAGES(2), .SIGNED(0)) u_uns (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(u_in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_sat(in_sat),
    .out_valid(u_valid), .out_ready(out_ready),
    .out_result(u_result), .out_carry(u_carry), .out_ovf(u_ovf),
    .out_zero(u_zero), .out_neg(u_neg)
`ifdef ADDSUB_STATS_EN
    , .stat_clr(stat_clr), .stat_ops(u_stat_ops), .stat_ovf(u_stat_ovf)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One isolated operation: accept, confirm 2-cycle latency, leave outputs valid for checking
  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic op, input logic sat);
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_sat = sat; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("lat_edge1_valid", s_valid, 1'b0);
    @(negedge clk);
    check("lat_edge2_valid", s_valid, 1'b1);
    check("lat_edge2_uvalid", u_valid, 1'b1);
  endtask

  logic [31:0] exp_q [$];
  logic [31:0] held;
  logic        was_stalled;
  int          sent, recv;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", s_valid, 1'b0);
    check("rst_out_result", s_result, 32'd0);
    check("rst_flags", {s_carry, s_ovf, s_zero, s_neg}, 4'b0000);
    check("rst_in_ready", s_in_ready, 1'b1);

    // 1: 7 - 5
    run(32'd7, 32'd5, 1'b1, 1'b0);
    check("t1_result", s_result, 32'd2);
    check("t1_flags", {s_carry, s_ovf, s_zero, s_neg}, 4'b1000);

    // 2: signed overflow, wrap then saturate
    run(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
    check("t2w_result", s_result, 32'h8000_0000);
    check("t2w_ovf_neg", {s_ovf, s_neg}, 2'b11);
    check("t2w_uns_ovf", u_ovf, 1'b0);
    run(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1);
    check("t2s_result", s_result, 32'h7FFF_FFFF);
    check("t2s_ovf_neg", {s_ovf, s_neg}, 2'b10);
    check("t2s_uns_result", u_result, 32'h8000_0000);

    // Signed negative overflow saturates to most-negative
    run(32'h8000_0000, 32'd1, 1'b1, 1'b1);
    check("tneg_result", s_result, 32'h8000_0000);
    check("tneg_ovf", s_ovf, 1'b1);

    // 3: unsigned borrow
    run(32'd3, 32'd5, 1'b1, 1'b0);
    check("t3w_result", u_result, 32'hFFFF_FFFE);
    check("t3w_carry_ovf", {u_carry, u_ovf}, 2'b01);
    check("t3w_sgn_ovf", s_ovf, 1'b0);
    run(32'd3, 32'd5, 1'b1, 1'b1);
    check("t3s_result", u_result, 32'd0);
    check("t3s_zero", u_zero, 1'b1);
    check("t3s_sgn_result", s_result, 32'hFFFF_FFFE);

    // Unsigned add carry saturates to all ones
    run(32'hFFFF_FFF0, 32'h20, 1'b0, 1'b1);
    check("tucarry_result", u_result, 32'hFFFF_FFFF);
    check("tucarry_flags", {u_carry, u_ovf}, 2'b11);

    // 4: backpressure stream of 8
    @(negedge clk);
    exp_q.delete();
    sent = 0; recv = 0; was_stalled = 1'b0; held = '0;
    for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
      if (cyc != 0) @(negedge clk);
      out_ready = !(cyc >= 3 && cyc <= 6);
      in_valid  = (sent < 8);
      in_a = 32'(sent * 10 + 1); in_b = 32'(sent); in_op = 1'b0; in_sat = 1'b0;
      #1;
      if (cyc >= 3 && cyc <= 6) check("t4_in_ready_stall", s_in_ready, 1'b0);
      if (was_stalled && s_valid) check("t4_held_stable", s_result, held);
      if (in_valid && s_in_ready) begin
        exp_q.push_back(32'(sent * 11 + 1));
        sent++;
      end
      if (s_valid && out_ready) begin
        if (exp_q.size() == 0) check("t4_unexpected_out", 1'b1, 1'b0);
        else check("t4_order", s_result, exp_q.pop_front());
        recv++;
      end
      was_stalled = s_valid && !out_ready;
      held = s_result;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("t4_recv_count", 64'(recv), 64'd8);
    @(negedge clk);
    check("t4_drained", s_valid, 1'b0);

    // 5: reset with two results in flight
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_a = 32'd10; in_b = 32'd1; in_op = 1'b0; in_sat = 1'b0;
    @(negedge clk);
    in_a = 32'd20;
    @(negedge clk);
    in_valid = 1'b0;
    check("t5_inflight", s_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t5_async_valid", s_valid, 1'b0);
    check("t5_async_result", s_result, 32'd0);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    #1;
    check("t5_in_ready", s_in_ready, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t5_no_stale", s_valid, 1'b0);
    end
    run(32'd1, 32'd1, 1'b0, 1'b0);
    check("t5_after_result", s_result, 32'd2);

`ifdef ADDSUB_STATS_EN
    // 6: counters (pulse clear first, after the pending transfer of the last op)
    @(negedge clk);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    check("t6_cleared_start", s_stat_ops, 32'd0);
    for (int k = 0; k < 10; k++) begin
      if (k == 2 || k == 5 || k == 8) run(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
      else run(32'(k), 32'd3, 1'b0, 1'b0);
    end
    @(negedge clk);
    check("t6_stat_ops", s_stat_ops, 32'd10);
    check("t6_stat_ovf", s_stat_ovf, 32'd3);
    check("t6_uns_stat_ovf", u_stat_ovf, 32'd0);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    check("t6_clr_ops", s_stat_ops, 32'd0);
    check("t6_clr_ovf", s_stat_ovf, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
Parametrised, pipelined add/subtract unit; next generation of the team's fixed 32-bit combinational subtractor.
- Adds WIDTH, pipeline depth, signed/unsigned mode, optional saturation and status flags.
- Uses a valid/ready handshake so it can sit between DMA-fed datapath stages in the CL with full backpressure.

Parameters:
WIDTH, 32, operand/result width in bits (legal 2..64)
STAGES, 2, pipeline register stages from input accept to output (legal 1..4)
SIGNED, 1, 1 = two's-complement overflow/saturation rules; 0 = unsigned rules

Ports:
clk  input  1  single clock, all logic rising-edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  input operands valid
in_ready  output  1  unit can accept input this cycle
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_op  input  1  0 = A+B, 1 = A-B
in_sat  input  1  1 = clamp result on overflow
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_result  output  WIDTH  result
out_carry  output  1  add: carry-out; sub: 1 = no borrow (A>=B unsigned)
out_ovf  output  1  overflow per SIGNED mode (raw result, before saturation)
out_zero  output  1  out_result == 0 (after saturation)
out_neg  output  1  MSB of out_result (after saturation)

Behaviour:
- Reset: all stage valid bits 0, all data/flag registers 0. Outputs: out_valid=0, out_result=0, all flags 0. in_ready=1 once rst deasserts.
- Reset mid-operation discards all in-flight results; nothing is emitted after reset.
- Transfer rules:
  - Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
  - Pipeline advance: adv = out_ready | ~out_valid; in_ready = adv (global stall, no bubble collapse required).
  - When adv=0, every stage holds its data and valid bit. out_result and flags must stay stable while out_valid=1 and out_ready=0.
- Latency: operands accepted at edge N appear with out_valid=1 after edge N+STAGES-1, i.e. STAGES cycles, absent stalls. Throughput is 1 per cycle with out_ready held high. Results are never reordered.
- Arithmetic is done in stage 1 on WIDTH+1 bits:
  - s = A + (op ? ~B : B) + op
  - carry = s[WIDTH]
- Overflow:
  - SIGNED=1: ovf = (A[MSB] == B'[MSB]) & (s[MSB] != A[MSB]), where B' = op ? ~B : B.
  - SIGNED=0: ovf = op ? ~carry : carry.
- Saturation (only when in_sat=1 and ovf=1):
  - SIGNED=1: A negative -> 100..0, else 011..1.
  - SIGNED=0: add -> all ones; sub -> 0.
  - With in_sat=0, the result wraps modulo 2^WIDTH.
- zero/neg are computed from the final (possibly saturated) result in stage 1. Stages 2..STAGES only delay data and flags.
- Bubbles: a stage with valid=0 may carry any data; only valid is meaningful.
- Simultaneous accept and emit in the same cycle is legal and must not drop or duplicate a result.

Optional Feature:
Macro ADDSUB_STATS_EN.
- Defined: extra outputs stat_ops (32 bits) and stat_ovf (32 bits).
  - stat_ops counts output transfers.
  - stat_ovf counts output transfers with out_ovf=1.
  - Both counters wrap at 2^32, reset to 0 on rst, and are registered (update the edge after the transfer).
  - Extra input stat_clr (1 bit) zeroes both counters synchronously. If stat_clr coincides with a transfer, clear wins.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. WIDTH=32, SIGNED=1, STAGES=2, out_ready=1: A=7, B=5, op=1 -> out_result=2, carry=1, ovf=0, zero=0, neg=0, valid exactly 2 cycles after accept.
2. Signed overflow, SIGNED=1:
   - A=0x7FFFFFFF, B=1, op=0, sat=0 -> result=0x80000000, ovf=1, neg=1.
   - Same operands with sat=1 -> result=0x7FFFFFFF, ovf=1, neg=0.
3. Unsigned borrow, SIGNED=0: A=3, B=5, op=1:
   - sat=0 -> 0xFFFFFFFE, carry=0, ovf=1.
   - sat=1 -> 0, zero=1.
4. Backpressure: stream 8 ops back-to-back, hold out_ready=0 for cycles 3-6 -> in_ready=0 during the stall, held result stable, all 8 results emitted in order with none lost or duplicated.
5. Reset mid-stream: assert rst with 2 results in flight -> out_valid=0 immediately (async), no stale result after release; next op (A=1, B=1, op=0) returns 2.
6. ADDSUB_STATS_EN defined: 10 transfers, 3 overflowing -> stat_ops=10, stat_ovf=3; then pulse stat_clr -> both 0.
